// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
//   ch_state_e  : per-channel state encoding (also exported on ch_state for debug)
//   LOSS_CNT_W  : width of each per-channel loss-of-lock counter
//   timer_width : bits needed for a timer covering the largest of three cycle counts
package pll_sup_pkg;

  localparam int LOSS_CNT_W = 8;
  localparam int ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } ch_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/pll_lock_channel.sv
// One supervised PLL: locked synchroniser, sequencing FSM, shared phase timer,
// retry counter and saturating loss-of-lock counter.
//   refclk      in   reference clock
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   raw (asynchronous) locked from the PLL
//   retry_req   in   one-cycle pulse, leaves FAIL
//   run_next    out  next state is RUN (feeds the release chain in the top)
//   pll_rst     out  registered active-high PLL reset
//   fail        out  registered, channel is in FAIL
//   loss_cnt    out  saturating loss-of-lock count
//   state       out  current state
//
// state      | meaning
// -----------+--------------------------------------------------------
// RESET      | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK  | pll_rst low, waiting up to LOCK_TIMEOUT cycles for lock
// DEBOUNCE   | locked seen, needs LOCK_STABLE consecutive high cycles
// RUN        | locked and stable, domain may be released
// FAIL       | MAX_RETRY attempts failed, PLL held in reset until retry_req
module pll_lock_channel
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  retry_req,
  output logic                  run_next,
  output logic                  pll_rst,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output ch_state_e             state
);

  localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // The timer is a down-counter loaded on state entry; a phase ends on the
  // cycle it reads zero, so loading N-1 gives exactly N cycles in the phase.
  localparam logic [TIMER_W-1:0] T_RST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_STABLE  = TIMER_W'(LOCK_STABLE - 1);

  logic                  sync1;
  logic                  locked_s;
  ch_state_e             state_nxt;
  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    timer_nxt;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [RETRY_W-1:0]    retry_nxt;
  logic [RETRY_W-1:0]    retry_inc;
  logic [LOSS_CNT_W-1:0] loss_nxt;

  assign retry_inc = retry_cnt + RETRY_W'(1);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      locked_s  <= 1'b0;
      state     <= ST_RESET;
      timer     <= T_RST;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      fail      <= 1'b0;
    end else begin
      sync1     <= pll_locked;
      locked_s  <= sync1;
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_rst   <= (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
      fail      <= (state_nxt == ST_FAIL);
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    if (timer != '0) timer_nxt = timer - TIMER_W'(1);
    case (state)
      ST_RESET: begin
        if (timer == '0) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = T_TIMEOUT;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (locked_s) begin
          state_nxt = ST_DEBOUNCE;
          timer_nxt = T_STABLE;
        end else if (timer == '0) begin
          retry_nxt = retry_inc;
          if (retry_inc == RETRY_W'(MAX_RETRY)) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_RESET;
            timer_nxt = T_RST;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = T_TIMEOUT;
        end else if (timer == '0) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt = ST_RESET;
          timer_nxt = T_RST;
          if (loss_cnt != '1) loss_nxt = loss_cnt + LOSS_CNT_W'(1);
        end
      end
      ST_FAIL: begin
        if (retry_req) begin
          state_nxt = ST_RESET;
          timer_nxt = T_RST;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        timer_nxt = T_RST;
      end
    endcase
  end

  assign run_next = (state_nxt == ST_RUN);

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises N_PLL PLLs sharing one reference clock and sequences the
// release of their clock-domain resets.
//   refclk        in   reference clock, the only clock
//   rst_n         in   synchronous active-low reset
//   pll_locked    in   raw locked per PLL (asynchronous)
//   retry_req     in   per-channel pulse, restarts a failed channel
//   pll_rst       out  active-high reset per PLL
//   domain_rst_n  out  registered active-low reset per clock domain
//   all_locked    out  registered AND of all domain_rst_n
//   fail          out  per-channel FAIL flag
//   loss_cnt      out  per-channel saturating loss count, channel i at [8i+7:8i]
//   ch_state      out  per-channel state code, channel i at [3i+2:3i]
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned N_PLL        = 2,
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ORDERED      = 1
) (
  input  logic                          refclk,
  input  logic                          rst_n,
  input  logic [N_PLL-1:0]              pll_locked,
  input  logic [N_PLL-1:0]              retry_req,
  output logic [N_PLL-1:0]              pll_rst,
  output logic [N_PLL-1:0]              domain_rst_n,
  output logic                          all_locked,
  output logic [N_PLL-1:0]              fail,
  output logic [N_PLL*LOSS_CNT_W-1:0]   loss_cnt,
  output logic [N_PLL*ST_W-1:0]         ch_state
);

  logic [N_PLL-1:0] run_next;
  logic [N_PLL-1:0] rel_ok;
  ch_state_e        ch_st [N_PLL];

  for (genvar g = 0; g < N_PLL; g++) begin : g_ch
    pll_lock_channel #(
      .RST_CYCLES  (RST_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .LOCK_STABLE (LOCK_STABLE),
      .MAX_RETRY   (MAX_RETRY)
    ) u_ch (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked[g]),
      .retry_req (retry_req[g]),
      .run_next  (run_next[g]),
      .pll_rst   (pll_rst[g]),
      .fail      (fail[g]),
      .loss_cnt  (loss_cnt[LOSS_CNT_W*g +: LOSS_CNT_W]),
      .state     (ch_st[g])
    );
    assign ch_state[ST_W*g +: ST_W] = ch_st[g];
  end

  // Release chain works on next states so a loss on channel j drops
  // domains j and above in the same cycle the channel leaves RUN.
  always_comb begin
    logic chain;
    chain  = 1'b1;
    rel_ok = '0;
    for (int i = 0; i < N_PLL; i++) begin
      rel_ok[i] = run_next[i] & chain;
      chain     = (ORDERED != 0) ? rel_ok[i] : 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      domain_rst_n <= '0;
      all_locked   <= 1'b0;
    end else begin
      domain_rst_n <= rel_ok;
      all_locked   <= &rel_ok;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int N_PLL        = 2;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;
  localparam int ORDERED      = 1;
  localparam int LOCK_LAT     = LOCK_STABLE + 3;

  logic        refclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pll_locked = '0;
  logic [1:0]  retry_req = '0;
  logic [1:0]  pll_rst;
  logic [1:0]  domain_rst_n;
  logic        all_locked;
  logic [1:0]  fail;
  logic [15:0] loss_cnt;
  logic [5:0]  ch_state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase codes 0..4 as listed for ch_state, elapsed counts up
  int m_phase   [2];
  int m_elapsed [2];
  int m_retries [2];
  int m_losses  [2];
  bit m_s1      [2];
  bit m_s2      [2];

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .N_PLL(N_PLL), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .MAX_RETRY(MAX_RETRY), .ORDERED(ORDERED)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .all_locked(all_locked),
    .fail(fail), .loss_cnt(loss_cnt), .ch_state(ch_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // leaves the bench at the negedge right after both channels enter WAIT_LOCK
  task automatic do_reset();
    pll_locked = '0;
    retry_req  = '0;
    rst_n      = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(RST_CYCLES);
  endtask

  function automatic void model_step(input logic rst_now, input logic [1:0] lk,
                                     input logic [1:0] rq);
    bit ls;
    for (int i = 0; i < 2; i++) begin
      if (!rst_now) begin
        m_phase[i] = 0; m_elapsed[i] = 0; m_retries[i] = 0; m_losses[i] = 0;
        m_s1[i] = 0; m_s2[i] = 0;
      end else begin
        ls = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = lk[i];
        case (m_phase[i])
          0: if (m_elapsed[i] + 1 == RST_CYCLES) begin m_phase[i] = 1; m_elapsed[i] = 0; end
             else m_elapsed[i]++;
          1: if (ls) begin m_phase[i] = 2; m_elapsed[i] = 0; end
             else if (m_elapsed[i] == LOCK_TIMEOUT - 1) begin
               m_retries[i]++;
               m_phase[i] = (m_retries[i] == MAX_RETRY) ? 4 : 0;
               m_elapsed[i] = 0;
             end else m_elapsed[i]++;
          2: if (!ls) begin m_phase[i] = 1; m_elapsed[i] = 0; end
             else if (m_elapsed[i] + 1 == LOCK_STABLE) begin
               m_phase[i] = 3; m_retries[i] = 0; m_elapsed[i] = 0;
             end else m_elapsed[i]++;
          3: if (!ls) begin
               m_phase[i] = 0; m_elapsed[i] = 0;
               m_losses[i] = (m_losses[i] < 255) ? m_losses[i] + 1 : 255;
             end
          default: if (rq[i]) begin m_phase[i] = 0; m_elapsed[i] = 0; m_retries[i] = 0; end
        endcase
      end
    end
  endfunction

  task automatic test_reset();
    pll_locked = '0; retry_req = '0; rst_n = 1'b0;
    tick(3);
    n_tests++; if (pll_rst !== 2'b11) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 11", pll_rst); end
    n_tests++; if (domain_rst_n !== 2'b00) begin n_fail++; $display("FAIL reset_domain: got %b expected 00", domain_rst_n); end
    n_tests++; if ({fail, all_locked} !== 3'b000) begin n_fail++; $display("FAIL reset_fail_all: got %b expected 000", {fail, all_locked}); end
    n_tests++; if (loss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_loss: got %h expected 0000", loss_cnt); end
    n_tests++; if (ch_state !== 6'o00) begin n_fail++; $display("FAIL reset_state: got %o expected 00", ch_state); end
    rst_n = 1'b1;
    tick(RST_CYCLES - 1);
    n_tests++; if (pll_rst !== 2'b11) begin n_fail++; $display("FAIL reset_hold: got %b expected 11", pll_rst); end
    tick(1);
    n_tests++; if (pll_rst !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %b expected 00", pll_rst); end
    n_tests++; if (ch_state !== 6'o11) begin n_fail++; $display("FAIL reset_wait_state: got %o expected 11", ch_state); end
  endtask

  task automatic test_normal_lock();
    pll_locked[0] = 1'b1;
    tick(LOCK_LAT - 1);
    n_tests++; if (domain_rst_n !== 2'b00) begin n_fail++; $display("FAIL lock0_early: got %b expected 00", domain_rst_n); end
    tick(1);
    n_tests++; if (domain_rst_n !== 2'b01) begin n_fail++; $display("FAIL lock0_release: got %b expected 01", domain_rst_n); end
    n_tests++; if (all_locked !== 1'b0) begin n_fail++; $display("FAIL lock0_all: got %b expected 0", all_locked); end
    pll_locked[1] = 1'b1;
    tick(LOCK_LAT - 1);
    n_tests++; if (domain_rst_n !== 2'b01) begin n_fail++; $display("FAIL lock1_early: got %b expected 01", domain_rst_n); end
    tick(1);
    n_tests++; if (domain_rst_n !== 2'b11) begin n_fail++; $display("FAIL lock1_release: got %b expected 11", domain_rst_n); end
    n_tests++; if (all_locked !== 1'b1) begin n_fail++; $display("FAIL lock1_all: got %b expected 1", all_locked); end
  endtask

  task automatic test_loss();
    pll_locked[0] = 1'b0;
    tick(3);
    n_tests++; if (domain_rst_n !== 2'b00) begin n_fail++; $display("FAIL loss_domain: got %b expected 00", domain_rst_n); end
    n_tests++; if (all_locked !== 1'b0) begin n_fail++; $display("FAIL loss_all: got %b expected 0", all_locked); end
    n_tests++; if (loss_cnt !== 16'h0001) begin n_fail++; $display("FAIL loss_cnt: got %h expected 0001", loss_cnt); end
    n_tests++; if (pll_rst !== 2'b01) begin n_fail++; $display("FAIL loss_pll_rst: got %b expected 01", pll_rst); end
    n_tests++; if (ch_state[5:3] !== 3'd3) begin n_fail++; $display("FAIL loss_ch1_run: got %0d expected 3", ch_state[5:3]); end
    tick(RST_CYCLES - 1);
    n_tests++; if (pll_rst[0] !== 1'b1) begin n_fail++; $display("FAIL loss_rst_hold: got %b expected 1", pll_rst[0]); end
    tick(1);
    n_tests++; if (pll_rst[0] !== 1'b0) begin n_fail++; $display("FAIL loss_rst_drop: got %b expected 0", pll_rst[0]); end
    pll_locked[0] = 1'b1;
    tick(LOCK_LAT);
    n_tests++; if (domain_rst_n !== 2'b11) begin n_fail++; $display("FAIL loss_relock: got %b expected 11", domain_rst_n); end
  endtask

  task automatic test_loss_saturate();
    int exp_loss;
    for (int k = 1; k <= 255; k++) begin
      pll_locked[0] = 1'b0;
      tick(3);
      exp_loss = (k + 1 > 255) ? 255 : k + 1;
      n_tests++;
      if (loss_cnt[7:0] !== 8'(exp_loss)) begin
        n_fail++; $display("FAIL sat_loss_%0d: got %0d expected %0d", k, loss_cnt[7:0], exp_loss);
      end
      tick(RST_CYCLES);
      pll_locked[0] = 1'b1;
      tick(LOCK_LAT);
    end
    n_tests++; if (loss_cnt !== 16'h00ff) begin n_fail++; $display("FAIL sat_final: got %h expected 00ff", loss_cnt); end
    n_tests++; if (domain_rst_n !== 2'b11) begin n_fail++; $display("FAIL sat_domain: got %b expected 11", domain_rst_n); end
  endtask

  task automatic test_ordering();
    int early;
    early = 0;
    do_reset();
    pll_locked[1] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick(1);
      if (c == 12) pll_locked[0] = 1'b1;
      if (domain_rst_n[1] !== 1'b0) early++;
    end
    n_tests++; if (early !== 0) begin n_fail++; $display("FAIL order_early: got %0d cycles high expected 0", early); end
    n_tests++; if (ch_state[5:3] !== 3'd3) begin n_fail++; $display("FAIL order_ch1_run: got %0d expected 3", ch_state[5:3]); end
    tick(1);
    n_tests++; if (domain_rst_n !== 2'b11) begin n_fail++; $display("FAIL order_release: got %b expected 11", domain_rst_n); end
  endtask

  task automatic test_glitch();
    do_reset();
    pll_locked = 2'b11;
    tick(5);
    pll_locked[0] = 1'b0;
    tick(1);
    pll_locked[0] = 1'b1;
    tick(2);
    n_tests++; if (ch_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL glitch_wait: got %0d expected 1", ch_state[2:0]); end
    tick(8);
    n_tests++; if (domain_rst_n !== 2'b00) begin n_fail++; $display("FAIL glitch_early: got %b expected 00", domain_rst_n); end
    tick(1);
    n_tests++; if (domain_rst_n !== 2'b11) begin n_fail++; $display("FAIL glitch_release: got %b expected 11", domain_rst_n); end
    n_tests++; if ({loss_cnt, fail} !== 18'h0) begin n_fail++; $display("FAIL glitch_loss_fail: got %h expected 0", {loss_cnt, fail}); end
  endtask

  task automatic test_timeout_fail();
    do_reset();
    pll_locked = 2'b01;
    tick(LOCK_TIMEOUT - 1);
    n_tests++; if (pll_rst[1] !== 1'b0) begin n_fail++; $display("FAIL to1_before: got %b expected 0", pll_rst[1]); end
    tick(1);
    n_tests++; if ({pll_rst[1], ch_state[5:3], fail[1]} !== 5'b1_000_0) begin n_fail++; $display("FAIL to1_retry: got %b expected 10000", {pll_rst[1], ch_state[5:3], fail[1]}); end
    tick(RST_CYCLES);
    n_tests++; if ({pll_rst[1], ch_state[5:3]} !== 4'b0_001) begin n_fail++; $display("FAIL to1_rewait: got %b expected 0001", {pll_rst[1], ch_state[5:3]}); end
    tick(LOCK_TIMEOUT - 1);
    n_tests++; if (fail[1] !== 1'b0) begin n_fail++; $display("FAIL to2_before: got %b expected 0", fail[1]); end
    tick(1);
    n_tests++; if ({fail, pll_rst[1], ch_state[5:3]} !== 6'b10_1_100) begin n_fail++; $display("FAIL to2_fail: got %b expected 101100", {fail, pll_rst[1], ch_state[5:3]}); end
    retry_req = 2'b01;
    tick(1);
    retry_req = 2'b00;
    tick(9);
    n_tests++; if ({fail[1], pll_rst[1], ch_state[5:3]} !== 5'b1_1_100) begin n_fail++; $display("FAIL fail_hold: got %b expected 11100", {fail[1], pll_rst[1], ch_state[5:3]}); end
    n_tests++; if ({ch_state[2:0], domain_rst_n} !== 5'b011_01) begin n_fail++; $display("FAIL fail_ch0_ignore: got %b expected 01101", {ch_state[2:0], domain_rst_n}); end
    retry_req = 2'b10;
    tick(1);
    retry_req = 2'b00;
    n_tests++; if ({fail[1], pll_rst[1], ch_state[5:3]} !== 5'b0_1_000) begin n_fail++; $display("FAIL retry_exit: got %b expected 01000", {fail[1], pll_rst[1], ch_state[5:3]}); end
    tick(RST_CYCLES - 1);
    n_tests++; if (pll_rst[1] !== 1'b1) begin n_fail++; $display("FAIL retry_rst_hold: got %b expected 1", pll_rst[1]); end
    tick(1);
    n_tests++; if (pll_rst[1] !== 1'b0) begin n_fail++; $display("FAIL retry_rst_drop: got %b expected 0", pll_rst[1]); end
  endtask

  task automatic test_random();
    int hold [2];
    bit stop;
    bit chain;
    logic [1:0]  e_rst, e_dom, e_fail;
    logic        e_all;
    logic [15:0] e_loss;
    logic [5:0]  e_st;
    stop = 0;
    hold[0] = 0; hold[1] = 0;
    rst_n = 1'b0; pll_locked = '0; retry_req = '0;
    for (int c = 0; c < 4000 && !stop; c++) begin
      @(posedge refclk);
      model_step(rst_n, pll_locked, retry_req);
      @(negedge refclk);
      chain = 1;
      for (int i = 0; i < 2; i++) begin
        e_rst[i]  = (m_phase[i] == 0) || (m_phase[i] == 4);
        e_fail[i] = (m_phase[i] == 4);
        chain     = chain && (m_phase[i] == 3);
        e_dom[i]  = chain;
        e_loss[8*i +: 8] = 8'(m_losses[i]);
        e_st[3*i +: 3]   = 3'(m_phase[i]);
      end
      e_all = chain;
      n_tests++;
      if ({pll_rst, domain_rst_n, fail, all_locked, loss_cnt, ch_state} !==
          {e_rst, e_dom, e_fail, e_all, e_loss, e_st}) begin
        n_fail++; stop = 1;
        $display("FAIL random_cycle_%0d: got rst=%b dom=%b fail=%b all=%b loss=%h st=%o expected rst=%b dom=%b fail=%b all=%b loss=%h st=%o",
                 c, pll_rst, domain_rst_n, fail, all_locked, loss_cnt, ch_state,
                 e_rst, e_dom, e_fail, e_all, e_loss, e_st);
      end
      rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          pll_locked[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 60);
        end else begin
          hold[i]--;
        end
        retry_req[i] = ($urandom_range(0, 15) == 0);
      end
    end
    retry_req = '0;
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_loss();
    test_loss_saturate();
    test_ordering();
    test_glitch();
    test_timeout_fail();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
